// File: rtl/pc_scheduler_array.sv
// Per-thread program-counter file with a round-robin fetch scheduler.
// Each cycle one active thread is chosen, starting the search at rr_ptr. That
// thread's PC goes to fetch, and the PC then post-increments by PC_STRIDE.
// Later pipeline stages start, halt and redirect threads; these take effect at the next edge.
module pc_scheduler_array #(
    parameter int unsigned THREAD_INDEX_BITS = 3,
    parameter int unsigned PC_WIDTH          = 8,
    parameter int unsigned PC_STRIDE         = 1,
    parameter int unsigned RESET_PC          = 0,
    parameter int unsigned RESET_ACTIVE_MASK = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_stall,
    input  logic                           in_redirect_valid,
    input  logic [THREAD_INDEX_BITS-1:0]   in_redirect_thread,
    input  logic [PC_WIDTH-1:0]            in_redirect_pc,
    input  logic                           in_start_valid,
    input  logic [THREAD_INDEX_BITS-1:0]   in_start_thread,
    input  logic [PC_WIDTH-1:0]            in_start_pc,
    input  logic                           in_halt_valid,
    input  logic [THREAD_INDEX_BITS-1:0]   in_halt_thread,
    output logic                           out_fetch_valid,
    output logic [THREAD_INDEX_BITS-1:0]   out_fetch_thread,
    output logic [PC_WIDTH-1:0]            out_fetch_pc,
    output logic [(1<<THREAD_INDEX_BITS)-1:0] out_active_mask,
    output logic                           out_idle
);

    localparam int unsigned N = 1 << THREAD_INDEX_BITS;

    logic [PC_WIDTH-1:0]          pc [N];
    logic [N-1:0]                 active;
    logic [THREAD_INDEX_BITS-1:0] rr_ptr;
    logic [THREAD_INDEX_BITS-1:0] sel;
    logic [THREAD_INDEX_BITS-1:0] idx;
    logic                         found;

    // Round-robin search for the first active thread at or after rr_ptr
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = rr_ptr + THREAD_INDEX_BITS'(k);
            if (!found && active[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Fetch outputs read the current state with zero latency; thread 0 is shown when nothing issues
    always_comb begin
        out_fetch_valid  = found & ~in_stall;
        out_fetch_thread = out_fetch_valid ? sel : '0;
        out_fetch_pc     = pc[out_fetch_thread];
        out_active_mask  = active;
        out_idle         = ~found;
    end

    // Per-thread update with same-thread priority halt > start > redirect > issue increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                pc[i] <= PC_WIDTH'(RESET_PC);
            end
            active <= N'(RESET_ACTIVE_MASK);
            rr_ptr <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (in_halt_valid && in_halt_thread == THREAD_INDEX_BITS'(i)) begin
                    active[i] <= 1'b0;
                end else if (in_start_valid && in_start_thread == THREAD_INDEX_BITS'(i)) begin
                    active[i] <= 1'b1;
                    pc[i]     <= in_start_pc;
                end else if (in_redirect_valid && in_redirect_thread == THREAD_INDEX_BITS'(i)) begin
                    pc[i] <= in_redirect_pc;
                end else if (out_fetch_valid && sel == THREAD_INDEX_BITS'(i)) begin
                    pc[i] <= pc[i] + PC_WIDTH'(PC_STRIDE);
                end
            end
            if (out_fetch_valid) begin
                rr_ptr <= sel + THREAD_INDEX_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_scheduler_array.sv
// Directed bench for pc_scheduler_array (default parameters, N=8).
module tb_pc_scheduler_array;

    logic       clk;
    logic       reset;
    logic       in_stall;
    logic       in_redirect_valid;
    logic [2:0] in_redirect_thread;
    logic [7:0] in_redirect_pc;
    logic       in_start_valid;
    logic [2:0] in_start_thread;
    logic [7:0] in_start_pc;
    logic       in_halt_valid;
    logic [2:0] in_halt_thread;
    logic       out_fetch_valid;
    logic [2:0] out_fetch_thread;
    logic [7:0] out_fetch_pc;
    logic [7:0] out_active_mask;
    logic       out_idle;

    int n_checks = 0;
    int n_errors = 0;

    pc_scheduler_array dut (
        .clk                (clk),
        .reset              (reset),
        .in_stall           (in_stall),
        .in_redirect_valid  (in_redirect_valid),
        .in_redirect_thread (in_redirect_thread),
        .in_redirect_pc     (in_redirect_pc),
        .in_start_valid     (in_start_valid),
        .in_start_thread    (in_start_thread),
        .in_start_pc        (in_start_pc),
        .in_halt_valid      (in_halt_valid),
        .in_halt_thread     (in_halt_thread),
        .out_fetch_valid    (out_fetch_valid),
        .out_fetch_thread   (out_fetch_thread),
        .out_fetch_pc       (out_fetch_pc),
        .out_active_mask    (out_active_mask),
        .out_idle           (out_idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_fetch(input string tag, input logic v, input logic [2:0] t, input logic [7:0] p);
        check({tag, "_valid"},  32'(out_fetch_valid),  32'(v));
        check({tag, "_thread"}, 32'(out_fetch_thread), 32'(t));
        check({tag, "_pc"},     32'(out_fetch_pc),     32'(p));
    endtask

    task automatic expect_mask(input string tag, input logic [7:0] m);
        check({tag, "_mask"}, 32'(out_active_mask), 32'(m));
        check({tag, "_idle"}, 32'(out_idle),        32'(m == 8'h00));
    endtask

    task automatic clear_inputs();
        in_stall           = 1'b0;
        in_redirect_valid  = 1'b0;
        in_redirect_thread = '0;
        in_redirect_pc     = '0;
        in_start_valid     = 1'b0;
        in_start_thread    = '0;
        in_start_pc        = '0;
        in_halt_valid      = 1'b0;
        in_halt_thread     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] t, input logic [7:0] p);
        in_start_valid = 1'b1; in_start_thread = t; in_start_pc = p;
    endtask

    task automatic do_halt(input logic [2:0] t);
        in_halt_valid = 1'b1; in_halt_thread = t;
    endtask

    task automatic do_redirect(input logic [2:0] t, input logic [7:0] p);
        in_redirect_valid = 1'b1; in_redirect_thread = t; in_redirect_pc = p;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #2;
        expect_fetch("rst", 1'b1, 3'd0, 8'h00);
        expect_mask("rst", 8'h01);
        #10 reset = 1'b0;
        #1;

        // thread 0 alone issues 0,1,2,3
        expect_fetch("t1_c0", 1'b1, 3'd0, 8'h00); tick();
        expect_fetch("t1_c1", 1'b1, 3'd0, 8'h01); tick();
        expect_fetch("t1_c2", 1'b1, 3'd0, 8'h02); tick();
        expect_fetch("t1_c3", 1'b1, 3'd0, 8'h03); tick();

        // start t3 and t5, round-robin t0,t3,t5,t0,...
        do_start(3'd3, 8'h40); #1;
        expect_fetch("t2_a", 1'b1, 3'd0, 8'h04); tick(); clear_inputs();
        do_start(3'd5, 8'h80); #1;
        expect_fetch("t2_b", 1'b1, 3'd3, 8'h40); tick(); clear_inputs();
        expect_fetch("t2_c", 1'b1, 3'd5, 8'h80); tick();
        expect_fetch("t2_d", 1'b1, 3'd0, 8'h05); tick();

        // redirect t3 in the cycle it issues 0x41
        do_redirect(3'd3, 8'h10); #1;
        expect_fetch("t3_a", 1'b1, 3'd3, 8'h41); tick(); clear_inputs();
        expect_fetch("t3_b", 1'b1, 3'd5, 8'h81); tick();

        // halt t0 while it issues
        do_halt(3'd0); #1;
        expect_fetch("t4_a", 1'b1, 3'd0, 8'h06); tick(); clear_inputs();
        expect_fetch("t4_b", 1'b1, 3'd3, 8'h10);
        expect_mask("t4_b", 8'h28); tick();
        do_halt(3'd3); #1;
        expect_fetch("t4_c", 1'b1, 3'd5, 8'h82); tick(); clear_inputs();
        do_halt(3'd5); #1;
        expect_fetch("t4_d", 1'b1, 3'd5, 8'h83); tick(); clear_inputs();
        expect_fetch("t4_idle0", 1'b0, 3'd0, 8'h06);
        expect_mask("t4_idle0", 8'h00); tick();

        // restart t0 at 0xFF to exercise wrap
        do_start(3'd0, 8'hFF); #1;
        expect_fetch("t4_idle1", 1'b0, 3'd0, 8'h06); tick(); clear_inputs();
        expect_fetch("t5_ff", 1'b1, 3'd0, 8'hFF); tick();

        // three stall cycles; t3 started during the stall
        in_stall = 1'b1;
        do_start(3'd3, 8'h30); #1;
        expect_fetch("t5_s1", 1'b0, 3'd0, 8'h00); tick();
        in_start_valid = 1'b0; #1;
        expect_fetch("t5_s2", 1'b0, 3'd0, 8'h00); tick();
        expect_fetch("t5_s3", 1'b0, 3'd0, 8'h00);
        expect_mask("t5_s3", 8'h09); tick();
        clear_inputs(); #1;
        expect_fetch("t5_o", 1'b1, 3'd3, 8'h30); tick();
        expect_fetch("t5_p", 1'b1, 3'd0, 8'h00); tick();

        // halt+start on same thread: halt wins
        do_halt(3'd3); do_start(3'd3, 8'h70); #1;
        expect_fetch("pri_hs", 1'b1, 3'd3, 8'h31); tick(); clear_inputs();
        // start+redirect on same thread: start wins
        do_start(3'd0, 8'h55); do_redirect(3'd0, 8'h66); #1;
        expect_fetch("pri_sr", 1'b1, 3'd0, 8'h01);
        expect_mask("pri_hs", 8'h01); tick(); clear_inputs();
        expect_fetch("pri_sr2", 1'b1, 3'd0, 8'h55);

        // asynchronous reset between edges, with pending start ignored
        #2 reset = 1'b1;
        #1;
        expect_fetch("t6_async", 1'b1, 3'd0, 8'h00);
        expect_mask("t6_async", 8'h01);
        do_start(3'd4, 8'h44);
        tick();
        expect_fetch("t6_hold", 1'b1, 3'd0, 8'h00);
        expect_mask("t6_hold", 8'h01);
        clear_inputs();
        #2 reset = 1'b0;
        #1;
        expect_fetch("t6_rel", 1'b1, 3'd0, 8'h00); tick();
        expect_fetch("t6_next", 1'b1, 3'd0, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
